lsu_mem_ctrl: RTL and testbench

//  Load/store unit between the core datapath (ALU address, rs2 data, mem_read/mem_write, funct3)
//  and a word-wide data memory with a req/ack handshake and variable latency.

---
 rtl/lsu_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
//   Load/store unit that sits between the core datapath and a word-wide data
//   memory. The memory uses a req/ack handshake with variable latency.
//   The unit:
//     - builds the byte enables and the lane-replicated store data,
//     - sign- or zero-extends the load data,
//     - stalls the core while an access is outstanding,
//     - aborts an access when the memory does not answer in time.
//
// Ports
//   clk, reset  : rising-edge clock; synchronous, active-high reset
//   mem_read    : core load request; held stable while stall=1
//   mem_write   : core store request; held stable while stall=1
//   funct3      : access size and sign
//                   000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr        : byte address from the ALU
//   wr_data     : store data (rs2)
//   load_data   : extended load result, valid while done=1
//   stall       : core must hold PC/instruction
//   done        : one-cycle pulse when the access completes
//   access_err  : one-cycle pulse for a misaligned or illegal request
//                 (no memory access is made)
//   bus_err     : one-cycle pulse, together with done, on a timeout abort
//   m_req, m_we, m_addr, m_be, m_wdata
//               : memory request; all held stable until m_ack
//   m_rdata     : memory read word, sampled on m_ack
//   m_ack       : single-cycle memory completion; ignored outside BUSY
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [DATA_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     load_data,
  output logic                  stall,
  output logic                  done,
  output logic                  access_err,
  output logic                  bus_err,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DM_ADDRESS-1:0] m_addr,
  output logic [3:0]            m_be,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ack
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Size/sign/alignment legality.
  // The unsigned variants (BU, HU) only exist for loads.
  function automatic logic is_legal(input logic [2:0] f3, input logic is_load,
                                    input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = (off[0] == 1'b0);
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = is_load;
      3'b101:  ok = is_load & (off[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables. Only funct3[1:0] matters, so BU/HU share the B/H patterns.
  function automatic logic [3:0] calc_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the store data so that every lane carries the low bytes.
  // This way the memory only has to honour m_be.
  function automatic logic [DATA_W-1:0] calc_wdata(input logic [1:0] sz,
                                                   input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] w;
    w = wd;
    case (sz)
      2'b00:   w = {4{wd[7:0]}};
      2'b01:   w = {2{wd[15:0]}};
      2'b10:   w = wd;
      default: w = wd;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down to bit 0, then extend it according to funct3.
  function automatic logic [DATA_W-1:0] extend_load(input logic [2:0] f3,
                                                    input logic [1:0] off,
                                                    input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] res;
    lane = rdata >> {off, 3'b000};
    res  = {DATA_W{1'b0}};
    case (f3)
      3'b000:  res = {{(DATA_W-8){lane[7]}}, lane[7:0]};
      3'b001:  res = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      3'b010:  res = rdata;
      3'b100:  res = {{(DATA_W-8){1'b0}}, lane[7:0]};
      3'b101:  res = {{(DATA_W-16){1'b0}}, lane[15:0]};
      default: res = {DATA_W{1'b0}};
    endcase
    return res;
  endfunction

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  m_req_q, m_req_d;
  logic                  m_we_q, m_we_d;
  logic [DM_ADDRESS-1:0] m_addr_q, m_addr_d;
  logic [3:0]            m_be_q, m_be_d;
  logic [DATA_W-1:0]     m_wdata_q, m_wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_W-1:0]     load_data_q, load_data_d;
  logic                  done_q, done_d;
  logic                  access_err_q, access_err_d;
  logic                  bus_err_q, bus_err_d;

  logic acc_s;
  logic legal_s;
  logic unused_addr_hi_s;

  assign acc_s   = mem_read ^ mem_write;
  assign legal_s = is_legal(funct3, mem_read, addr[1:0]);

  // Address bits above the word address do not reach the memory.
  assign unused_addr_hi_s = ^addr[DATA_W-1:DM_ADDRESS+2];

  // Combinational stall: the core is held from the very cycle a legal request
  // appears, so it never advances past an access that has not finished.
  assign stall = ((state_q == S_IDLE) & acc_s & legal_s) | (state_q == S_BUSY);

  // Next-state and registered-output logic for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_be_d       = m_be_q;
    m_wdata_d    = m_wdata_q;
    f3_d         = f3_q;
    off_d        = off_q;
    load_data_d  = load_data_q;
    done_d       = 1'b0;
    access_err_d = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (acc_s && legal_s) begin
          state_d   = S_BUSY;
          cnt_d     = {CNT_W{1'b0}};
          m_req_d   = 1'b1;
          m_we_d    = mem_write;
          m_addr_d  = addr[DM_ADDRESS+1:2];
          m_be_d    = calc_be(funct3[1:0], addr[1:0]);
          m_wdata_d = calc_wdata(funct3[1:0], wr_data);
          f3_d      = funct3;
          off_d     = addr[1:0];
        end else if (mem_read || mem_write) begin
          // Illegal or ambiguous request: flag it and never touch the memory.
          access_err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BUSY: begin
        if (m_ack) begin
          // An ack on the last allowed cycle still wins over the abort.
          m_req_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
          if (!m_we_q) begin
            load_data_d = extend_load(f3_q, off_q, m_rdata);
          end else begin
            load_data_d = load_data_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          m_req_d     = 1'b0;
          load_data_d = {DATA_W{1'b0}};
          bus_err_d   = 1'b1;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= {DM_ADDRESS{1'b0}};
      m_be_q       <= 4'b0000;
      m_wdata_q    <= {DATA_W{1'b0}};
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      load_data_q  <= {DATA_W{1'b0}};
      done_q       <= 1'b0;
      access_err_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_be_q       <= m_be_d;
      m_wdata_q    <= m_wdata_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      load_data_q  <= load_data_d;
      done_q       <= done_d;
      access_err_q <= access_err_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign load_data  = load_data_q;
  assign done       = done_q;
  assign access_err = access_err_q;
  assign bus_err    = bus_err_q;
  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_be       = m_be_q;
  assign m_wdata    = m_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl.
// Expected values come from a byte-level model of the load/store rules:
// size and alignment arithmetic, lane shifts and masks, and the last load value.
module tb_lsu_mem_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] load_data;
  logic        stall, done, access_err, bus_err;
  logic        m_req, m_we;
  logic [8:0]  m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'd0;
  logic        m_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_load = 32'd0;

  lsu_mem_ctrl #(.DATA_W(32), .DM_ADDRESS(9), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wr_data(wr_data), .load_data(load_data),
    .stall(stall), .done(done), .access_err(access_err), .bus_err(bus_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  // One complete access, checked cycle by cycle against the model.
  // ack_dly = k asserts m_ack in the k-th BUSY cycle.
  // A delay outside 1..TIMEOUT never acks, so the access times out.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdw, input int ack_dly,
                           input bit b2b, input string tag);
    int size;
    int off;
    bit f3_ok;
    bit legal;
    bit tmo;
    int busy;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_ld;
    longint unsigned lane;
    longint unsigned mask;
    logic [15:0] exp_busy;
    logic [15:0] got_busy;

    off  = int'(a % 32'd4);
    size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    f3_ok = (f3 <= 3'd2) || (rd && !wr && (f3 == 3'd4 || f3 == 3'd5));
    legal = (rd != wr) && f3_ok && ((off % size) == 0);
    exp_be = 4'(((1 << size) - 1) << off);
    exp_wd = (size == 1) ? wd[7:0] * 32'h0101_0101 :
             (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    lane = longint'(rdw) >> (8 * off);
    mask = (size == 4) ? 64'hFFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    lane = lane & mask;
    if (!f3[2] && size < 4 && ((lane >> (8 * size - 1)) & 64'd1) == 64'd1) begin
      lane = lane | (~mask);
    end
    exp_ld = lane[31:0];
    tmo  = !(ack_dly >= 1 && ack_dly <= TIMEOUT);
    busy = tmo ? TIMEOUT : ack_dly;

    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wr_data = wd; m_ack = 1'b0;
    #1;
    if (!legal) begin
      checks++;
      if ({stall, m_req, access_err} !== 3'b000) begin
        errors++;
        $display("FAIL %s err_req_cycle {stall,m_req,access_err}: got %b exp 000",
                 tag, {stall, m_req, access_err});
      end
      @(negedge clk); mem_read = 1'b0; mem_write = 1'b0; #1;
      checks++;
      if ({access_err, stall, m_req, done} !== 4'b1000) begin
        errors++;
        $display("FAIL %s err_pulse {access_err,stall,m_req,done}: got %b exp 1000",
                 tag, {access_err, stall, m_req, done});
      end
      @(negedge clk); #1;
      checks++;
      if ({access_err, m_req} !== 2'b00 || load_data !== model_load) begin
        errors++;
        $display("FAIL %s err_after: access_err=%b m_req=%b load_data=%h exp 0 0 %h",
                 tag, access_err, m_req, load_data, model_load);
      end
      return;
    end

    checks++;
    if ({stall, m_req, done} !== 3'b100) begin
      errors++;
      $display("FAIL %s idle_cycle {stall,m_req,done}: got %b exp 100",
               tag, {stall, m_req, done});
    end

    for (int c = 1; c <= busy; c++) begin
      @(negedge clk);
      m_ack   = (!tmo && c == ack_dly);
      m_rdata = m_ack ? rdw : $urandom;
      #1;
      exp_busy = {1'b1, 1'b1, wr, a[10:2], exp_be, 1'b0};
      got_busy = {stall, m_req, m_we, m_addr, m_be, done};
      checks++;
      if (got_busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy%0d {stall,m_req,m_we,m_addr,m_be,done}: got %h exp %h",
                 tag, c, got_busy, exp_busy);
      end
      if (wr) begin
        checks++;
        if (m_wdata !== exp_wd) begin
          errors++;
          $display("FAIL %s busy%0d m_wdata: got %h exp %h", tag, c, m_wdata, exp_wd);
        end
      end
    end

    if (tmo) model_load = 32'd0;
    else if (rd) model_load = exp_ld;

    @(negedge clk); m_ack = 1'b0; m_rdata = $urandom; #1;
    checks++;
    if ({done, stall, m_req, bus_err, access_err} !== {1'b1, 1'b0, 1'b0, tmo, 1'b0}) begin
      errors++;
      $display("FAIL %s done_cycle {done,stall,m_req,bus_err,access_err}: got %b exp %b",
               tag, {done, stall, m_req, bus_err, access_err}, {1'b1, 1'b0, 1'b0, tmo, 1'b0});
    end
    checks++;
    if (load_data !== model_load) begin
      errors++;
      $display("FAIL %s load_data: got %h exp %h", tag, load_data, model_load);
    end

    if (!b2b) begin
      @(negedge clk); mem_read = 1'b0; mem_write = 1'b0; #1;
      checks++;
      if ({done, bus_err, stall, m_req} !== 4'b0000 || load_data !== model_load) begin
        errors++;
        $display("FAIL %s after_done: done=%b bus_err=%b stall=%b m_req=%b load_data=%h exp 0 0 0 0 %h",
                 tag, done, bus_err, stall, m_req, load_data, model_load);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0; #1;
    model_load = 32'd0;
    checks++;
    if ({load_data, stall, done, access_err, bus_err, m_req, m_we, m_addr, m_be, m_wdata} !== 84'd0) begin
      errors++;
      $display("FAIL reset_state: load_data=%h stall=%b done=%b aerr=%b berr=%b m_req=%b m_we=%b m_addr=%h m_be=%b m_wdata=%h exp all 0",
               load_data, stall, done, access_err, bus_err, m_req, m_we, m_addr, m_be, m_wdata);
    end
  endtask

  task automatic test_store_word();
    do_access(1'b0, 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0, 2, 1'b0, "sw_08");
  endtask

  task automatic test_byte_loads();
    do_access(1'b1, 1'b0, 3'b000, 32'h0B, 32'h0, 32'h80123456, 1, 1'b0, "lb_0b");
    do_access(1'b1, 1'b0, 3'b100, 32'h0B, 32'h0, 32'h80123456, 3, 1'b0, "lbu_0b");
    do_access(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 32'h0000_7F00, 1, 1'b0, "lb_pos");
  endtask

  task automatic test_half();
    do_access(1'b1, 1'b0, 3'b001, 32'h06, 32'h0, 32'h7FFF8001, 1, 1'b0, "lh_06");
    do_access(1'b1, 1'b0, 3'b001, 32'h04, 32'h0, 32'h7FFF8001, 2, 1'b0, "lh_04");
    do_access(1'b1, 1'b0, 3'b101, 32'h04, 32'h0, 32'h7FFF8001, 1, 1'b0, "lhu_04");
    do_access(1'b0, 1'b1, 3'b001, 32'h06, 32'h00001234, 32'h0, 1, 1'b0, "sh_06");
    do_access(1'b0, 1'b1, 3'b000, 32'h1FD, 32'h000000A5, 32'h0, 1, 1'b0, "sb_1fd");
  endtask

  task automatic test_access_err();
    do_access(1'b1, 1'b0, 3'b010, 32'h05, 32'h0, 32'h0, 1, 1'b0, "lw_mis");
    do_access(1'b1, 1'b0, 3'b001, 32'h03, 32'h0, 32'h0, 1, 1'b0, "lh_mis");
    do_access(1'b1, 1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1, 1'b0, "f3_011");
    do_access(1'b0, 1'b1, 3'b100, 32'h00, 32'h0, 32'h0, 1, 1'b0, "sbu_ill");
    do_access(1'b1, 1'b1, 3'b010, 32'h00, 32'h0, 32'h0, 1, 1'b0, "rd_and_wr");
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h11223344, 1, 1'b0, "pre_tmo");
    do_access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h55667788, TIMEOUT, 1'b0, "ack_at_limit");
    do_access(1'b1, 1'b0, 3'b010, 32'h48, 32'h0, 32'h0, TIMEOUT + 1, 1'b0, "tmo_load");
    do_access(1'b0, 1'b1, 3'b010, 32'h4C, 32'hCAFEBABE, 32'h0, 0, 1'b0, "tmo_store");
  endtask

  task automatic test_ack_outside_busy();
    do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hA5A5_5A5A, 1, 1'b0, "pre_ack_idle");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); m_ack = 1'b1; m_rdata = $urandom; #1;
      checks++;
      if ({m_req, done, bus_err, stall} !== 4'b0000 || load_data !== model_load) begin
        errors++;
        $display("FAIL ack_idle%0d: m_req=%b done=%b bus_err=%b stall=%b load_data=%h exp 0 0 0 0 %h",
                 i, m_req, done, bus_err, stall, load_data, model_load);
      end
    end
    @(negedge clk); m_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0BAD_F00D, 1, 1'b1, "b2b_0");
    do_access(1'b0, 1'b1, 3'b000, 32'h102, 32'h0000_0077, 32'h0, 1, 1'b1, "b2b_1");
    do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8000_1234, 1, 1'b1, "b2b_2");
    do_access(1'b1, 1'b0, 3'b010, 32'h07, 32'h0, 32'h0, 1, 1'b1, "b2b_err");
  endtask

  task automatic test_random();
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    int r, dly;
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      dly = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 2) : $urandom_range(1, 4);
      do_access(rd, wr, f3, a, $urandom, $urandom, dly, bit'($urandom_range(0, 1)), "rand");
    end
  endtask

  task automatic test_reset_in_busy();
    do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFE_F00D, 1, 1'b0, "pre_rst");
    @(negedge clk); mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h20; #1;
    @(negedge clk); #1;
    checks++;
    if ({stall, m_req} !== 2'b11) begin
      errors++;
      $display("FAIL rst_busy_req {stall,m_req}: got %b exp 11", {stall, m_req});
    end
    @(negedge clk); reset = 1'b1; #1;
    @(negedge clk); reset = 1'b0; mem_read = 1'b0; m_ack = 1'b1; m_rdata = 32'h1234_5678; #1;
    model_load = 32'd0;
    checks++;
    if ({m_req, stall, done, bus_err} !== 4'b0000 || load_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_busy_drop: m_req=%b stall=%b done=%b bus_err=%b load_data=%h exp 0 0 0 0 0",
               m_req, stall, done, bus_err, load_data);
    end
    @(negedge clk); m_ack = 1'b0; #1;
    checks++;
    if ({done, m_req} !== 2'b00 || load_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_late_ack: done=%b m_req=%b load_data=%h exp 0 0 0", done, m_req, load_data);
    end
    do_access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFE_0000, 2, 1'b0, "post_rst");
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_byte_loads();
    test_half();
    test_access_err();
    test_timeout();
    test_ack_outside_busy();
    test_back_to_back();
    test_random();
    test_reset_in_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
